// File: rtl/cdb_broadcaster_pkg.sv
// Shared types for the CDB broadcaster: tag width, source encoding and the
// registered broadcast packet.
package cdb_broadcaster_pkg;

   localparam int PREG_IDX_WIDTH = 6;
   localparam int NUM_CDB_SRC    = 3;

   typedef enum logic [1:0] {
      CDB_SRC_ALU  = 2'd0,
      CDB_SRC_MULT = 2'd1,
      CDB_SRC_LSQ  = 2'd2
   } CDB_SRC;

   typedef struct packed {
      logic                      valid;
      logic [PREG_IDX_WIDTH-1:0] tag;
   } CDB_PACKET;

   // Cyclic successor used both for round-robin search order and pointer update
   function automatic CDB_SRC cdbSrcNext(input CDB_SRC src);
      case (src)
         CDB_SRC_ALU:  return CDB_SRC_MULT;
         CDB_SRC_MULT: return CDB_SRC_LSQ;
         default:      return CDB_SRC_ALU;
      endcase
   endfunction

endpackage

// File: rtl/cdb_broadcaster_if.sv
// Completion/broadcast bundle between the functional units and the CDB
// broadcaster; the broadcaster takes the slave side.
interface cdb_broadcaster_if;
   import cdb_broadcaster_pkg::*;

   logic                      alu_done;
   logic [PREG_IDX_WIDTH-1:0] alu_tag;
   logic                      mult_done;
   logic [PREG_IDX_WIDTH-1:0] mult_tag;
   logic                      lsq_done;
   logic [PREG_IDX_WIDTH-1:0] lsq_tag;
   logic                      alu_stall;
   logic                      mult_stall;
   logic                      lsq_stall;
   logic                      cdb_valid;
   logic [PREG_IDX_WIDTH-1:0] cdb_tag;

   modport master (
      output alu_done, alu_tag, mult_done, mult_tag, lsq_done, lsq_tag,
      input  alu_stall, mult_stall, lsq_stall, cdb_valid, cdb_tag
   );

   modport slave (
      input  alu_done, alu_tag, mult_done, mult_tag, lsq_done, lsq_tag,
      output alu_stall, mult_stall, lsq_stall, cdb_valid, cdb_tag
   );

endinterface

// File: rtl/cdb_broadcaster_src.sv
// Per-source completion tag FIFO (power-of-two depth, wrapping pointers);
// module cdb_src_fifo, instantiated once per functional unit.
module cdb_src_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 6
) (
   input  logic                     i_clock,
   input  logic                     i_reset,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [WIDTH-1:0]         i_data,
   output logic [WIDTH-1:0]         o_head,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full,
   output logic                     o_empty
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_headPtr;
   logic [PTR_W-1:0] r_tailPtr;
   logic [PTR_W:0]   r_count;

   // Storage is not reset; pointers and count define what is valid
   always_ff @(posedge i_clock) begin
      if (i_push) begin
         r_mem[r_tailPtr] <= i_data;
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_headPtr <= '0;
         r_tailPtr <= '0;
         r_count   <= '0;
      end else begin
         if (i_push) begin
            r_tailPtr <= r_tailPtr + PTR_W'(1);
         end
         if (i_pop) begin
            r_headPtr <= r_headPtr + PTR_W'(1);
         end
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + (PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head  = r_mem[r_headPtr];
   assign o_count = r_count;
   assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
   assign o_empty = (r_count == '0);

endmodule

// File: rtl/cdb_broadcaster.sv
// CDB broadcaster: buffers ALU/MULT/LSQ completion tags and broadcasts one per
// cycle with round-robin arbitration. CDB_DEBUG_EN adds count/grant/pointer outputs.
module cdb_broadcaster
   import cdb_broadcaster_pkg::*;
#(
   parameter int CDB_BUF_DEPTH = 2
) (
   input  logic clock,
   input  logic reset,
   cdb_broadcaster_if.slave bus
`ifdef CDB_DEBUG_EN
   ,
   output logic [$clog2(CDB_BUF_DEPTH):0] debug_alu_count,
   output logic [$clog2(CDB_BUF_DEPTH):0] debug_mult_count,
   output logic [$clog2(CDB_BUF_DEPTH):0] debug_lsq_count,
   output logic [2:0]                     debug_grant,
   output logic [1:0]                     debug_rr_ptr
`endif
);
   localparam int CNT_W = $clog2(CDB_BUF_DEPTH) + 1;

   logic                      w_done    [NUM_CDB_SRC];
   logic [PREG_IDX_WIDTH-1:0] w_tag     [NUM_CDB_SRC];
   logic [PREG_IDX_WIDTH-1:0] w_head    [NUM_CDB_SRC];
   logic [PREG_IDX_WIDTH-1:0] w_candTag [NUM_CDB_SRC];
   logic [CNT_W-1:0]          w_count   [NUM_CDB_SRC];
   logic                      w_full    [NUM_CDB_SRC];
   logic                      w_empty   [NUM_CDB_SRC];
   logic                      w_stall   [NUM_CDB_SRC];
   logic                      w_accept  [NUM_CDB_SRC];
   logic                      w_cand    [NUM_CDB_SRC];
   logic                      w_push    [NUM_CDB_SRC];
   logic                      w_pop     [NUM_CDB_SRC];
   CDB_SRC                    w_order   [NUM_CDB_SRC];
   logic [NUM_CDB_SRC-1:0]    w_grant1h;
   logic                      w_grantFound;
   CDB_SRC                    w_grantSrc;
   CDB_SRC                    w_rrPtrNext;
   CDB_PACKET                 w_cdbNext;
   CDB_SRC                    r_rrPtr;
   CDB_PACKET                 r_cdb;

   assign w_done[CDB_SRC_ALU]  = bus.alu_done;
   assign w_done[CDB_SRC_MULT] = bus.mult_done;
   assign w_done[CDB_SRC_LSQ]  = bus.lsq_done;
   assign w_tag[CDB_SRC_ALU]   = bus.alu_tag;
   assign w_tag[CDB_SRC_MULT]  = bus.mult_tag;
   assign w_tag[CDB_SRC_LSQ]   = bus.lsq_tag;

   assign bus.alu_stall  = w_stall[CDB_SRC_ALU];
   assign bus.mult_stall = w_stall[CDB_SRC_MULT];
   assign bus.lsq_stall  = w_stall[CDB_SRC_LSQ];
   assign bus.cdb_valid  = r_cdb.valid;
   assign bus.cdb_tag    = r_cdb.tag;

   // An empty FIFO lets a fresh done compete directly (bypass) for this cycle
   for (genvar gi = 0; gi < NUM_CDB_SRC; gi++) begin : g_src
      assign w_stall[gi]   = (w_count[gi] == CNT_W'(CDB_BUF_DEPTH));
      assign w_accept[gi]  = w_done[gi] && !w_full[gi];
      assign w_cand[gi]    = !w_empty[gi] || (w_done[gi] && w_empty[gi]);
      assign w_candTag[gi] = w_empty[gi] ? w_tag[gi] : w_head[gi];

      cdb_src_fifo #(
         .DEPTH (CDB_BUF_DEPTH),
         .WIDTH (PREG_IDX_WIDTH)
      ) u_fifo (
         .i_clock (clock),
         .i_reset (reset),
         .i_push  (w_push[gi]),
         .i_pop   (w_pop[gi]),
         .i_data  (w_tag[gi]),
         .o_head  (w_head[gi]),
         .o_count (w_count[gi]),
         .o_full  (w_full[gi]),
         .o_empty (w_empty[gi])
      );
   end

   assign w_order[0] = r_rrPtr;
   assign w_order[1] = cdbSrcNext(r_rrPtr);
   assign w_order[2] = cdbSrcNext(w_order[1]);

   always_comb begin
      w_grantFound = 1'b0;
      w_grantSrc   = r_rrPtr;
      for (int k = 0; k < NUM_CDB_SRC; k++) begin
         if (!w_grantFound && w_cand[w_order[k]]) begin
            w_grantFound = 1'b1;
            w_grantSrc   = w_order[k];
         end
      end
   end

   // Winner via bypass is never enqueued; a winner with a head may pop and push together
   always_comb begin
      w_cdbNext.valid = w_grantFound;
      w_cdbNext.tag   = r_cdb.tag;
      w_rrPtrNext     = r_rrPtr;
      w_grant1h       = '0;
      if (w_grantFound) begin
         w_cdbNext.tag          = w_candTag[w_grantSrc];
         w_rrPtrNext            = cdbSrcNext(w_grantSrc);
         w_grant1h[w_grantSrc]  = 1'b1;
      end
      for (int i = 0; i < NUM_CDB_SRC; i++) begin
         w_pop[i]  = w_grant1h[i] && !w_empty[i];
         w_push[i] = w_accept[i] && !(w_grant1h[i] && w_empty[i]);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_cdb   <= '0;
         r_rrPtr <= CDB_SRC_ALU;
      end else begin
         r_cdb   <= w_cdbNext;
         r_rrPtr <= w_rrPtrNext;
      end
   end

`ifdef CDB_DEBUG_EN
   logic [NUM_CDB_SRC-1:0] r_grant;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_grant <= '0;
      end else begin
         r_grant <= w_grant1h;
      end
   end

   assign debug_alu_count  = w_count[CDB_SRC_ALU];
   assign debug_mult_count = w_count[CDB_SRC_MULT];
   assign debug_lsq_count  = w_count[CDB_SRC_LSQ];
   assign debug_grant      = r_grant;
   assign debug_rr_ptr     = r_rrPtr;
`endif

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Directed vector bench for cdb_broadcaster: a table of single-cycle vectors
// plus hand-written fill/stall and reset-flush sequences.
module tb_cdb_broadcaster;
   import cdb_broadcaster_pkg::*;

   localparam int DEPTH = 2;

   logic clock = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

   cdb_broadcaster_if cdbIf ();

`ifdef CDB_DEBUG_EN
   logic [$clog2(DEPTH):0] dbgAluCount;
   logic [$clog2(DEPTH):0] dbgMultCount;
   logic [$clog2(DEPTH):0] dbgLsqCount;
   logic [2:0]             dbgGrant;
   logic [1:0]             dbgRrPtr;
`endif

   cdb_broadcaster #(
      .CDB_BUF_DEPTH (DEPTH)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (cdbIf)
`ifdef CDB_DEBUG_EN
      ,
      .debug_alu_count  (dbgAluCount),
      .debug_mult_count (dbgMultCount),
      .debug_lsq_count  (dbgLsqCount),
      .debug_grant      (dbgGrant),
      .debug_rr_ptr     (dbgRrPtr)
`endif
   );

   always #5 clock = ~clock;

   // One cycle of inputs and the registered/stall outputs expected after that edge
   typedef struct {
      int rst;
      int ad; int at;
      int md; int mt;
      int ld; int lt;
      int ev; int et; int es;
   } vec_t;

   vec_t vecs [18];
   int   expA [9];
   int   expB [3];
   int   aluNext;
   int   multNext;
   bit   aluDo;
   bit   multDo;
   bit   aluAcc;
   bit   multAcc;
   bit   sawMultStall;

   task automatic stepCycle;
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input int rst, input int ad, input int at,
                                input int md, input int mt,
                                input int ld, input int lt);
      reset           = (rst != 0);
      cdbIf.alu_done  = (ad != 0);
      cdbIf.alu_tag   = PREG_IDX_WIDTH'(at);
      cdbIf.mult_done = (md != 0);
      cdbIf.mult_tag  = PREG_IDX_WIDTH'(mt);
      cdbIf.lsq_done  = (ld != 0);
      cdbIf.lsq_tag   = PREG_IDX_WIDTH'(lt);
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   function automatic int stallBits();
      return int'({cdbIf.alu_stall, cdbIf.mult_stall, cdbIf.lsq_stall});
   endfunction

   initial begin
      // Reset for two cycles, then ten idle cycles
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      stepCycle;
      stepCycle;
      checkOutput("reset_valid", int'(cdbIf.cdb_valid), 0);
      checkOutput("reset_tag", int'(cdbIf.cdb_tag), 0);
      checkOutput("reset_stalls", stallBits(), 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         stepCycle;
         checkOutput($sformatf("idle%0d_valid", i), int'(cdbIf.cdb_valid), 0);
      end

      //          rst ad at md mt ld lt  ev et es
      vecs[0]  = '{1, 0, 0, 0, 0, 0, 0,  0, 0, 3'b000};
      vecs[1]  = '{1, 1, 9, 0, 0, 0, 0,  0, 0, 3'b000};
      vecs[2]  = '{0, 0, 0, 0, 0, 0, 0,  0, 0, 3'b000};
      vecs[3]  = '{0, 1, 1, 1, 2, 1, 3,  1, 1, 3'b000};
      vecs[4]  = '{0, 0, 0, 0, 0, 0, 0,  1, 2, 3'b000};
      vecs[5]  = '{0, 0, 0, 0, 0, 0, 0,  1, 3, 3'b000};
      vecs[6]  = '{0, 0, 0, 0, 0, 0, 0,  0, 3, 3'b000};
      vecs[7]  = '{0, 1, 5, 0, 0, 0, 0,  1, 5, 3'b000};
      vecs[8]  = '{0, 0, 0, 0, 0, 0, 0,  0, 5, 3'b000};
      vecs[9]  = '{0, 1, 7, 1, 30, 0, 0, 1, 30, 3'b000};
      vecs[10] = '{0, 1, 8, 0, 0, 0, 0,  1, 7, 3'b000};
      vecs[11] = '{0, 0, 0, 0, 0, 0, 0,  1, 8, 3'b000};
      vecs[12] = '{0, 0, 0, 0, 0, 0, 0,  0, 8, 3'b000};
      vecs[13] = '{0, 1, 50, 1, 40, 0, 0, 1, 40, 3'b000};
      vecs[14] = '{0, 1, 51, 0, 0, 1, 60, 1, 60, 3'b100};
      vecs[15] = '{0, 1, 52, 0, 0, 0, 0, 1, 50, 3'b000};
      vecs[16] = '{0, 0, 0, 0, 0, 0, 0,  1, 51, 3'b000};
      vecs[17] = '{0, 0, 0, 0, 0, 0, 0,  0, 51, 3'b000};

      for (int i = 0; i < 18; i++) begin
         applyStimulus(vecs[i].rst, vecs[i].ad, vecs[i].at, vecs[i].md, vecs[i].mt,
                       vecs[i].ld, vecs[i].lt);
         stepCycle;
         checkOutput($sformatf("vec%0d_valid", i), int'(cdbIf.cdb_valid), vecs[i].ev);
         checkOutput($sformatf("vec%0d_tag", i), int'(cdbIf.cdb_tag), vecs[i].et);
         checkOutput($sformatf("vec%0d_stalls", i), stallBits(), vecs[i].es);
      end

      // MULT fill and stall against continuous ALU; units hold a tag while stalled
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      stepCycle;
      expA = '{20, 10, 21, 11, 22, 12, 23, 13, 24};
      aluNext      = 20;
      multNext     = 10;
      sawMultStall = 1'b0;
      for (int c = 0; c < 10; c++) begin
         aluDo   = (aluNext <= 24);
         multDo  = (multNext <= 13);
         aluAcc  = aluDo && !cdbIf.alu_stall;
         multAcc = multDo && !cdbIf.mult_stall;
         applyStimulus(0, int'(aluDo), aluNext, int'(multDo), multNext, 0, 0);
         stepCycle;
         if (aluAcc) aluNext++;
         if (multAcc) multNext++;
         if (cdbIf.mult_stall) sawMultStall = 1'b1;
         if (c < 9) begin
            checkOutput($sformatf("fill%0d_valid", c), int'(cdbIf.cdb_valid), 1);
            checkOutput($sformatf("fill%0d_tag", c), int'(cdbIf.cdb_tag), expA[c]);
         end else begin
            checkOutput("fill_drain_valid", int'(cdbIf.cdb_valid), 0);
         end
      end
      checkOutput("fill_mult_stall_seen", int'(sawMultStall), 1);
      checkOutput("fill_mult_all_accepted", multNext, 14);
      checkOutput("fill_alu_all_accepted", aluNext, 25);

      // Buffer entries in every source, then reset and confirm nothing survives
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      stepCycle;
      expB = '{40, 50, 60};
      for (int c = 0; c < 3; c++) begin
         applyStimulus(0, 1, 40 + c, 1, 50 + c, 1, 60 + c);
         stepCycle;
         checkOutput($sformatf("flush_fill%0d_tag", c), int'(cdbIf.cdb_tag), expB[c]);
      end
      checkOutput("flush_full_stalls", stallBits(), 3'b110);
      applyStimulus(1, 1, 42, 1, 52, 1, 62);
      stepCycle;
      checkOutput("flush_reset_valid", int'(cdbIf.cdb_valid), 0);
      checkOutput("flush_reset_tag", int'(cdbIf.cdb_tag), 0);
      checkOutput("flush_reset_stalls", stallBits(), 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      for (int c = 0; c < 4; c++) begin
         stepCycle;
         checkOutput($sformatf("flush_idle%0d_valid", c), int'(cdbIf.cdb_valid), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
